// File: rtl/cmd_seq_driver.sv
// Command sequencer that replays stored command words to a RemoteComm link and checks each response.
// Build option: define CMD_SEQ_CONT_EN to keep running remaining slots after an error instead of aborting.
module cmd_seq_driver #(
    parameter int          DEPTH = 8,
    parameter int          TMO_W = 20,
    parameter logic [7:0]  ACK   = 8'hA5,
    localparam int         AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [15:0]     wr_data,
    input  logic [CW-1:0]   num_cmds,
    input  logic            start,
    output logic [15:0]     cmd,
    output logic            snd_cmd,
    input  logic            cmd_snt,
    input  logic            resp_rdy,
    input  logic [7:0]      resp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [1:0]      err_code,
    output logic [AW-1:0]   fail_idx,
    output logic [CW-1:0]   err_cnt
);

    // The wait counter holds the number of waiting cycles already spent; the cycle on which
    // it reads TMO_LAST is the (2^TMO_W-1)th waiting cycle, where the timeout fires.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((64'd1 << TMO_W) - 64'd2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_NEXT,
        S_DONE
    } state_t;

    state_t           state;
    logic [AW-1:0]    idx;
    logic [CW-1:0]    count;
    logic [TMO_W-1:0] tmo;
    logic [15:0]      mem [DEPTH];

    logic             tmo_fire;
    logic             last_slot;
    logic [CW-1:0]    num_sat;
    logic [CW-1:0]    err_cnt_inc;
    logic             err_ev;
    logic [1:0]       err_val;

    // Command memory has no reset so stored sequences survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign tmo_fire    = (tmo == TMO_LAST);
    assign last_slot   = (CW'(idx) == (count - 1'b1));
    assign num_sat     = (num_cmds > CW'(DEPTH)) ? CW'(DEPTH) : num_cmds;
    assign err_cnt_inc = (err_cnt == CW'(DEPTH)) ? err_cnt : (err_cnt + 1'b1);

    always_comb begin
        err_ev  = 1'b0;
        err_val = 2'd0;
        case (state)
            S_WAIT_SNT: begin
                if (!cmd_snt && tmo_fire) begin
                    err_ev  = 1'b1;
                    err_val = 2'd2;
                end
            end
            S_WAIT_RESP: begin
                // A response arriving on the timeout cycle still counts as a response.
                if (resp_rdy) begin
                    if (resp != ACK) begin
                        err_ev  = 1'b1;
                        err_val = 2'd1;
                    end
                end else if (tmo_fire) begin
                    err_ev  = 1'b1;
                    err_val = 2'd3;
                end
            end
            default: begin
                err_ev  = 1'b0;
                err_val = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            count    <= '0;
            tmo      <= '0;
            cmd      <= '0;
            snd_cmd  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= 2'd0;
            fail_idx <= '0;
            err_cnt  <= '0;
        end else begin
            snd_cmd <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        err_code <= 2'd0;
                        fail_idx <= '0;
                        err_cnt  <= '0;
                        idx      <= '0;
                        count    <= num_sat;
                        if (num_sat == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state   <= S_SEND;
                            busy    <= 1'b1;
                            snd_cmd <= 1'b1;
                            cmd     <= mem[0];
                        end
                    end
                end
                S_SEND: begin
                    tmo   <= '0;
                    state <= S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    if (cmd_snt) begin
                        tmo   <= '0;
                        state <= S_WAIT_RESP;
                    end else if (!tmo_fire) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_rdy) begin
                        if (resp == ACK) begin
                            state <= S_NEXT;
                        end
                    end else if (!tmo_fire) begin
                        tmo <= tmo + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (last_slot) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == '0);
                    end else begin
                        idx     <= idx + 1'b1;
                        cmd     <= mem[idx + 1'b1];
                        snd_cmd <= 1'b1;
                        state   <= S_SEND;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (err_ev) begin
                err_cnt <= err_cnt_inc;
                if (err_code == 2'd0) begin
                    err_code <= err_val;
                    fail_idx <= idx;
                end
`ifdef CMD_SEQ_CONT_EN
                state <= S_NEXT;
`else
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_cmd_seq_driver.sv
// Self-checking bench for cmd_seq_driver: plays the RemoteComm side from per-slot plans and
// compares against an outcome model of the sequence (sent words, error summary, event latency).
module tb_cmd_seq_driver;

    localparam int DEPTH    = 8;
    localparam int TMO_W    = 4;
    localparam int AW       = 3;
    localparam int CW       = 4;
    localparam int TMO_WAIT = 15;
`ifdef CMD_SEQ_CONT_EN
    localparam int CONT = 1;
`else
    localparam int CONT = 0;
`endif

    localparam int O_OK  = 0;
    localparam int O_NAK = 1;
    localparam int O_SNT = 2;
    localparam int O_RSP = 3;
    localparam int O_RST = 4;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [CW-1:0] num_cmds;
    logic          start;
    logic [15:0]   cmd;
    logic          snd_cmd;
    logic          cmd_snt;
    logic          resp_rdy;
    logic [7:0]    resp;
    logic          busy;
    logic          done;
    logic          pass;
    logic [1:0]    err_code;
    logic [AW-1:0] fail_idx;
    logic [CW-1:0] err_cnt;

    cmd_seq_driver #(.DEPTH(DEPTH), .TMO_W(TMO_W), .ACK(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .num_cmds (num_cmds),
        .start    (start),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_code (err_code),
        .fail_idx (fail_idx),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [15:0] mem_m  [DEPTH];
    int          p_out  [DEPTH];
    int          p_d    [DEPTH];
    int          p_r    [DEPTH];
    logic [7:0]  p_val  [DEPTH];
    bit          p_spur [DEPTH];

    task automatic write_slot(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a[AW-1:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic all_ok();
        for (int i = 0; i < DEPTH; i++) begin
            p_out[i]  = O_OK;
            p_d[i]    = 1;
            p_r[i]    = 2;
            p_val[i]  = 8'hA5;
            p_spur[i] = 1'b0;
        end
    endtask

    task automatic rand_plans();
        int r;
        logic [7:0] v;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 99);
            p_out[i]  = (r < 60) ? O_OK : (r < 75) ? O_NAK : (r < 85) ? O_SNT : O_RSP;
            p_d[i]    = $urandom_range(0, 5);
            p_r[i]    = $urandom_range(0, 5);
            v         = 8'($urandom_range(0, 255));
            p_val[i]  = (v == 8'hA5) ? 8'h5A : v;
            p_spur[i] = 1'($urandom_range(0, 1));
        end
    endtask

    // Called at the cycle where snd_cmd was seen; returns the expected number of cycles
    // from the point of return until the next snd_cmd or done.
    task automatic run_slot(input int k, input bit inject, output int exp_lat, output bit was_rst);
        was_rst = 1'b0;
        if (inject && k == 0) begin
            start    = 1'b1;
            num_cmds = 4'd1;
            wr_en    = 1'b1;
            wr_addr  = 3'd3;
            wr_data  = 16'hDEAD;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check("snd_one_cycle", snd_cmd, 1'b0);
        if (p_out[k] == O_SNT) begin
            exp_lat = TMO_WAIT + CONT;
            return;
        end
        if (p_spur[k] && p_d[k] > 0) begin
            resp_rdy = 1'b1;
            resp     = 8'h00;
            @(negedge clk);
            resp_rdy = 1'b0;
            repeat (p_d[k] - 1) @(negedge clk);
        end else begin
            repeat (p_d[k]) @(negedge clk);
        end
        cmd_snt = 1'b1;
        @(negedge clk);
        cmd_snt = 1'b0;
        if (p_out[k] == O_RSP) begin
            exp_lat = TMO_WAIT + CONT;
            return;
        end
        if (p_out[k] == O_RST) begin
            #2 rst_n = 1'b0;
            #1 check("async_reset_outs",
                     {cmd, snd_cmd, busy, done, pass, err_code, fail_idx, err_cnt}, 32'd0);
            @(negedge clk);
            rst_n   = 1'b1;
            was_rst = 1'b1;
            exp_lat = 0;
            return;
        end
        repeat (p_r[k]) @(negedge clk);
        resp_rdy = 1'b1;
        resp     = (p_out[k] == O_NAK) ? p_val[k] : 8'hA5;
        @(negedge clk);
        resp_rdy = 1'b0;
        exp_lat  = (p_out[k] == O_OK) ? 1 : CONT;
    endtask

    task automatic run_seq(input int n, input bit inject);
        int n_eff, exp_sent, exp_code, exp_fidx, exp_cnt;
        int lat, exp_lat, k;
        bit rst_hit;

        n_eff    = (n > DEPTH) ? DEPTH : n;
        exp_sent = n_eff;
        exp_code = 0;
        exp_fidx = 0;
        exp_cnt  = 0;
        for (int i = 0; i < n_eff; i++) begin
            if (p_out[i] == O_RST) begin
                exp_sent = i + 1;
                break;
            end
            if (p_out[i] != O_OK) begin
                if (exp_cnt == 0) begin
                    exp_code = p_out[i];
                    exp_fidx = i;
                end
                exp_cnt++;
                if (CONT == 0) begin
                    exp_sent = i + 1;
                    break;
                end
            end
        end

        num_cmds = n[CW-1:0];
        start    = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        exp_lat = 0;
        k       = 0;
        rst_hit = 1'b0;
        forever begin
            lat = 0;
            while (!snd_cmd && !done && lat < 200) begin
                @(negedge clk);
                lat++;
            end
            check("event_latency", lat, exp_lat);
            if (lat >= 200 || done) break;
            if (k >= exp_sent) begin
                check("extra_send", k, exp_sent);
                break;
            end
            check("cmd_word", cmd, mem_m[k]);
            check("busy_running", {busy, done}, 2'b10);
            run_slot(k, inject, exp_lat, rst_hit);
            k++;
            if (rst_hit) break;
        end
        if (!rst_hit) begin
            check("sent_count", k, exp_sent);
            check("done_state", {done, busy, snd_cmd}, 3'b100);
            check("pass", pass, 1'(exp_cnt == 0));
            check("err_code", err_code, exp_code);
            check("fail_idx", fail_idx, exp_fidx);
            check("err_cnt", err_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        num_cmds = '0;
        start    = 1'b0;
        cmd_snt  = 1'b0;
        resp_rdy = 1'b0;
        resp     = 8'h00;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset_outs", {cmd, snd_cmd, busy, done, pass, err_code, fail_idx, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) write_slot(i, 16'h0100 + 16'(i));

        // two-command calibration sequence
        write_slot(0, 16'h2000);
        write_slot(1, 16'h4BF4);
        all_ok();
        run_seq(2, 1'b0);

        // slot 1 negatively acknowledged
        write_slot(2, 16'h1234);
        all_ok();
        p_out[1] = O_NAK;
        p_val[1] = 8'h5A;
        run_seq(3, 1'b0);

        // cmd_snt never arrives
        all_ok();
        p_out[0] = O_SNT;
        run_seq(1, 1'b0);

        // ACK on the timeout cycle
        all_ok();
        p_r[0] = 14;
        run_seq(1, 1'b0);

        // empty sequence
        run_seq(0, 1'b0);

        // start and write during a four-command run are ignored
        write_slot(3, 16'h3C3C);
        all_ok();
        run_seq(4, 1'b1);

        // reset in WAIT_RESP of slot 2, then replay from slot 0
        all_ok();
        p_out[2] = O_RST;
        run_seq(3, 1'b0);
        all_ok();
        run_seq(3, 1'b0);

        // oversize count saturates to DEPTH
        all_ok();
        run_seq(12, 1'b0);

        repeat (30) begin
            if ($urandom_range(0, 2) == 0)
                write_slot($urandom_range(0, DEPTH - 1), 16'($urandom));
            rand_plans();
            run_seq($urandom_range(0, 10), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
